// File: rtl/synth_pkg.sv
// Shared types and default widths for the loop-RAM scheduler.
package synth_pkg;

  localparam int unsigned SYNTH_SAMPLE_W   = 16;
  localparam int unsigned SYNTH_RAM_ADDR_W = 23;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitAck
  } sched_state_t;

  typedef enum logic {
    Wr,
    Rd
  } grant_t;

endpackage

// File: rtl/ring_ptr.sv
// Wrap counter: steps by one on inc and returns to zero after reaching limit-1.
module ring_ptr #(
  parameter int unsigned W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q, ptr_d;

  // Modular compare: a limit of 2**W (truncated to 0) wraps at all-ones.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == limit - W'(1)) ? '0 : ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/loop_ram_scheduler.sv
// Shares one RAM port between record writes and playback reads of a circular loop buffer.
module loop_ram_scheduler
  import synth_pkg::*;
#(
  parameter int unsigned ADDR_W  = SYNTH_RAM_ADDR_W,
  parameter int unsigned DATA_W  = SYNTH_SAMPLE_W,
  parameter int unsigned MAX_LEN = 2**20,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_strobe,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_strobe,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] loop_len,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] MaxLenL = LEN_W'(MAX_LEN);

  sched_state_t state_q, state_d;
  grant_t       grant_q, last_grant_q, pick;

  logic              wr_pend_q, rd_pend_q;
  logic [DATA_W-1:0] wr_data_q, rd_data_q, wdata_q;
  logic [ADDR_W-1:0] addr_q, wr_ptr, rd_ptr;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q, rd_valid_q, discard_q, overrun_q, timeout_q;

  logic both, can_grant, empty_rd, start, acked, timed_out, drop;
  logic wr_fin, rd_fin, wr_commit, rd_commit;

  // Round-robin only matters under contention; last_grant tracks contended grants.
  always_comb begin
    pick = Rd;
    if (wr_pend_q && (!rd_pend_q || last_grant_q == Rd)) begin
      pick = Wr;
    end
  end

  assign both      = wr_pend_q & rd_pend_q;
  assign can_grant = (state_q == StIdle) && (wr_pend_q || rd_pend_q) && !clear;
  assign empty_rd  = can_grant && (pick == Rd) && (len_q == '0);
  assign start     = can_grant && !empty_rd;
  assign acked     = (state_q == StWaitAck) && mem_ack;
  assign timed_out = (state_q == StWaitAck) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign drop      = discard_q | clear;
  assign wr_fin    = (acked || timed_out) && (grant_q == Wr);
  assign rd_fin    = ((acked || timed_out) && (grant_q == Rd)) || empty_rd;
  assign wr_commit = acked && (grant_q == Wr) && !drop;
  assign rd_commit = acked && (grant_q == Rd) && !drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StIssue;
      StIssue:   state_d = StWaitAck;
      StWaitAck: if (acked || timed_out) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    busy    = 1'b0;
    if (state_q != StIdle) begin
      mem_req = 1'b1;
      busy    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      wr_data_q    <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      wdata_q      <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      grant_q      <= Wr;
      last_grant_q <= Rd;
      len_q        <= '0;
      cnt_q        <= '0;
      discard_q    <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      if (clear)          wr_pend_q <= 1'b0;
      else if (wr_strobe) wr_pend_q <= 1'b1;
      else if (wr_fin)    wr_pend_q <= 1'b0;

      if (clear)          rd_pend_q <= 1'b0;
      else if (rd_strobe) rd_pend_q <= 1'b1;
      else if (rd_fin)    rd_pend_q <= 1'b0;

      if (wr_strobe && !clear) wr_data_q <= wr_data;

      // A strobe landing on its own completion re-arms the flag instead of overrunning.
      if (!clear && ((wr_strobe && wr_pend_q && !wr_fin) ||
                     (rd_strobe && rd_pend_q && !rd_fin))) begin
        overrun_q <= 1'b1;
      end
      if (timed_out) timeout_q <= 1'b1;

      if (can_grant && both) last_grant_q <= pick;

      if (start) begin
        grant_q <= pick;
        we_q    <= (pick == Wr);
        addr_q  <= (pick == Wr) ? wr_ptr : rd_ptr;
        if (pick == Wr) wdata_q <= wr_data_q;
        cnt_q   <= '0;
      end else if (state_q != StIdle) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (clear && state_q != StIdle) discard_q <= 1'b1;
      else if (state_q == StIdle)     discard_q <= 1'b0;

      rd_valid_q <= rd_commit | empty_rd;
      if (rd_commit)     rd_data_q <= mem_rdata;
      else if (empty_rd) rd_data_q <= '0;

      if (clear) begin
        len_q <= '0;
      end else if (wr_commit && len_q != MaxLenL) begin
        len_q <= len_q + LEN_W'(1);
      end
    end
  end

  ring_ptr #(.W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (wr_commit),
    .limit (ADDR_W'(MAX_LEN)),
    .ptr   (wr_ptr)
  );

  ring_ptr #(.W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (rd_commit),
    .limit (len_q[ADDR_W-1:0]),
    .ptr   (rd_ptr)
  );

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign loop_len    = len_q[ADDR_W-1:0];
  assign err_overrun = overrun_q;
  assign err_timeout = timeout_q;

endmodule

// File: tb/tb_loop_ram_scheduler.sv
// Directed bench for loop_ram_scheduler with MAX_LEN=8 and TIMEOUT=64.
module tb_loop_ram_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, clear, wr_strobe, rd_strobe, mem_ack;
  logic [15:0] wr_data, mem_rdata, rd_data, mem_wdata;
  logic [22:0] mem_addr, loop_len;
  logic        rd_valid, mem_req, mem_we, busy, err_overrun, err_timeout;

  int vecs = 0;
  int errs = 0;
  logic [15:0] ram [0:15];

  loop_ram_scheduler #(
    .ADDR_W  (23),
    .DATA_W  (16),
    .MAX_LEN (8),
    .TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .wr_strobe   (wr_strobe),
    .wr_data     (wr_data),
    .rd_strobe   (rd_strobe),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .loop_len    (loop_len),
    .busy        (busy),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe_wr(input logic [15:0] d);
    wr_strobe = 1'b1;
    wr_data   = d;
    tick;
    wr_strobe = 1'b0;
  endtask

  task automatic strobe_rd;
    rd_strobe = 1'b1;
    tick;
    rd_strobe = 1'b0;
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
  endtask

  // Acts as the RAM controller: waits for a request, acks after delay cycles.
  task automatic serve(input int delay, output logic we, output logic [22:0] addr,
                       output logic [15:0] wdata, output int lat);
    lat = 0;
    while (!mem_req && lat < 20) begin
      tick;
      lat++;
    end
    we    = mem_we;
    addr  = mem_addr;
    wdata = mem_wdata;
    if (we) ram[addr[3:0]] = wdata;
    repeat (delay) tick;
    mem_ack   = 1'b1;
    mem_rdata = we ? 16'hFFFF : ram[addr[3:0]];
    tick;
    mem_ack   = 1'b0;
    mem_rdata = 16'hFFFF;
  endtask

  initial begin
    logic        we;
    logic [22:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_rd [0:3];
    int          lat, hi;
    logic        seen_v, seen_req;

    exp_rd[0] = 16'hA000; exp_rd[1] = 16'hA001; exp_rd[2] = 16'hA002; exp_rd[3] = 16'hA003;
    rst_n = 1'b0; clear = 1'b0; wr_strobe = 1'b0; rd_strobe = 1'b0;
    mem_ack = 1'b0; wr_data = '0; mem_rdata = 16'hFFFF;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    check("rst_mem_req", mem_req, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_loop_len", loop_len, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {err_overrun, err_timeout}, 0);
    check("rst_mem_addr", mem_addr, 0);

    // First write, ack three cycles after mem_req
    strobe_wr(16'h1234);
    check("wr1_req_not_yet", mem_req, 0);
    serve(3, we, addr, wd, lat);
    check("wr1_req_latency", lat, 1);
    check("wr1_we", we, 1);
    check("wr1_addr", addr, 0);
    check("wr1_wdata", wd, 16'h1234);
    check("wr1_req_drops", mem_req, 0);
    check("wr1_len", loop_len, 1);
    check("wr1_no_rd_valid", rd_valid, 0);

    // Four samples then six reads wrapping over the loop
    pulse_clear;
    check("clr_len", loop_len, 0);
    for (int i = 0; i < 4; i++) begin
      strobe_wr(16'hA000 + 16'(i));
      serve(1, we, addr, wd, lat);
      check("rec_addr", addr, i);
    end
    check("rec_len", loop_len, 4);
    for (int i = 0; i < 6; i++) begin
      strobe_rd;
      serve(1, we, addr, wd, lat);
      check("pb_we", we, 0);
      check("pb_addr", addr, i % 4);
      check("pb_valid", rd_valid, 1);
      check("pb_data", rd_data, exp_rd[i % 4]);
      tick;
      check("pb_valid_one_cycle", rd_valid, 0);
    end

    // Contention with loop_len = 2
    pulse_clear;
    strobe_wr(16'hB000);
    serve(1, we, addr, wd, lat);
    strobe_wr(16'hB001);
    serve(1, we, addr, wd, lat);
    check("ct_len", loop_len, 2);
    wr_strobe = 1'b1; rd_strobe = 1'b1; wr_data = 16'hC000;
    tick;
    wr_strobe = 1'b0; rd_strobe = 1'b0;
    serve(1, we, addr, wd, lat);
    check("ct1_first_is_wr", we, 1);
    check("ct1_wr_addr", addr, 2);
    serve(1, we, addr, wd, lat);
    check("ct1_second_is_rd", we, 0);
    check("ct1_rd_addr", addr, 0);
    check("ct1_rd_data", rd_data, 16'hB000);
    wr_strobe = 1'b1; rd_strobe = 1'b1; wr_data = 16'hC001;
    tick;
    wr_strobe = 1'b0; rd_strobe = 1'b0;
    serve(1, we, addr, wd, lat);
    check("ct2_first_is_rd", we, 0);
    check("ct2_rd_addr", addr, 1);
    check("ct2_rd_data", rd_data, 16'hB001);
    serve(1, we, addr, wd, lat);
    check("ct2_second_is_wr", we, 1);
    check("ct2_wr_addr", addr, 3);
    check("ct2_wdata", wd, 16'hC001);
    check("ct_no_overrun", err_overrun, 0);

    // Read from an empty loop: no RAM access, zero sample
    pulse_clear;
    seen_req = 1'b0;
    strobe_rd;
    seen_req |= mem_req;
    tick;
    seen_req |= mem_req;
    check("empty_valid", rd_valid, 1);
    check("empty_data", rd_data, 0);
    repeat (4) begin
      tick;
      seen_req |= mem_req;
    end
    check("empty_no_req", seen_req, 0);
    check("empty_not_busy", busy, 0);

    // Withheld ack: timeout, plus an overrun during the wait
    strobe_wr(16'h5A5A);
    serve(1, we, addr, wd, lat);
    strobe_rd;
    lat = 0;
    while (!mem_req && lat < 20) begin
      tick;
      lat++;
    end
    hi = 0;
    seen_v = 1'b0;
    while (mem_req && hi < 200) begin
      hi++;
      if (hi == 5) rd_strobe = 1'b1;
      tick;
      rd_strobe = 1'b0;
      seen_v |= rd_valid;
    end
    check("to_req_cycles", hi, 64);
    check("to_err_timeout", err_timeout, 1);
    check("to_err_overrun", err_overrun, 1);
    check("to_no_rd_valid", seen_v, 0);
    check("to_len_kept", loop_len, 1);
    strobe_rd;
    serve(2, we, addr, wd, lat);
    check("to_rd_ptr_kept", addr, 0);
    check("to_retry_data", rd_data, 16'h5A5A);

    // Clear while a read waits for its ack
    strobe_rd;
    lat = 0;
    while (!mem_req && lat < 20) begin
      tick;
      lat++;
    end
    tick;
    pulse_clear;
    check("clr_req_held", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick;
    mem_ack = 1'b0; mem_rdata = 16'hFFFF;
    check("clr_no_valid", rd_valid, 0);
    check("clr_req_low", mem_req, 0);
    check("clr_len_zero", loop_len, 0);
    check("clr_rd_data_kept", rd_data, 16'h5A5A);

    // Nine writes into an eight-sample loop
    for (int i = 0; i < 9; i++) begin
      strobe_wr(16'hD000 + 16'(i));
      serve(1, we, addr, wd, lat);
      check("wrap_addr", addr, i % 8);
      check("wrap_len", loop_len, (i < 8) ? i + 1 : 8);
    end
    strobe_rd;
    serve(1, we, addr, wd, lat);
    check("wrap_rd_addr", addr, 0);
    check("wrap_rd_data", rd_data, 16'hD008);

    // Reset in the middle of an access
    strobe_wr(16'hEEEE);
    lat = 0;
    while (!mem_req && lat < 20) begin
      tick;
      lat++;
    end
    check("mid_req_up", mem_req, 1);
    rst_n = 1'b0;
    tick;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_errs", {err_overrun, err_timeout}, 0);
    check("mid_rst_len", loop_len, 0);
    rst_n = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
